// File: rtl/chip8_exec_unit_if.sv
// Decode-side and memory-side handshake bundle for the CHIP-8 execute unit.
interface chip8_exec_unit_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_KEYS = 16
);
  // ceil(DATA_W*log10(2)) in integer arithmetic
  localparam int DIGITS = (DATA_W * 30103 + 99999) / 100000;
  localparam int OFF_W  = $clog2(DIGITS);

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [5:0]          op;
  logic [DATA_W-1:0]   vx;
  logic [DATA_W-1:0]   vy;
  logic [7:0]          imm;
  logic [NUM_KEYS-1:0] keys;
  logic [DATA_W-1:0]   rnd;
  logic                res_valid;
  logic                wb_en;
  logic [DATA_W-1:0]   wb_data;
  logic                vf_en;
  logic [DATA_W-1:0]   vf_data;
  logic                skip;
  logic                mem_valid;
  logic                mem_ready;
  logic [OFF_W-1:0]    mem_offset;
  logic [7:0]          mem_data;
  logic                trap;

  modport master (
    output flush, in_valid, op, vx, vy, imm, keys, rnd, mem_ready,
    input  in_ready, res_valid, wb_en, wb_data, vf_en, vf_data, skip,
           mem_valid, mem_offset, mem_data, trap
  );

  modport slave (
    input  flush, in_valid, op, vx, vy, imm, keys, rnd, mem_ready,
    output in_ready, res_valid, wb_en, wb_data, vf_en, vf_data, skip,
           mem_valid, mem_offset, mem_data, trap
  );
endinterface

// File: rtl/chip8_exec_unit.sv
// CHIP-8 execute stage: single-cycle ALU/skip ops, key-wait and serial BCD
// store with valid/ready stall, flush and unsupported-op trap.
module chip8_exec_unit #(
  parameter int DATA_W   = 8,
  parameter int NUM_KEYS = 16
) (
  input logic             clk,
  input logic             rst,
  chip8_exec_unit_if.slave bus
);
  localparam int DIGITS = (DATA_W * 30103 + 99999) / 100000;
  localparam int OFF_W  = $clog2(DIGITS);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int KEY_W  = $clog2(NUM_KEYS);
  localparam int CNT_W  = $clog2(DATA_W);

  localparam logic [5:0] OP_SE_B = 6,  OP_SE = 7,  OP_SNE_B = 8, OP_SNE = 9;
  localparam logic [5:0] OP_LD_B = 10, OP_LD = 11, OP_LD_K = 14, OP_BCD = 18;
  localparam logic [5:0] OP_ADDI = 21, OP_ADD = 22, OP_SUB = 24, OP_SUBN = 25;
  localparam logic [5:0] OP_OR = 26, OP_AND = 27, OP_XOR = 28, OP_SHR = 29;
  localparam logic [5:0] OP_SHL = 30, OP_RND = 31, OP_SKP = 33, OP_SKNP = 34;

  typedef enum logic [2:0] {IDLE, KEY_PRESS, KEY_RELEASE, BCD_CONV, BCD_EMIT} state_t;
  state_t state;

  logic              res_valid, wb_en, vf_en, skip, trap, mem_valid;
  logic [DATA_W-1:0] wb_data, vf_data;
  logic [OFF_W-1:0]  mem_offset;
  logic [7:0]        mem_data;
  logic [KEY_W-1:0]  key_idx;
  logic [DATA_W-1:0] bin;
  logic [BCD_W-1:0]  bcd;
  logic [CNT_W-1:0]  cnt;

  assign bus.in_ready   = (state == IDLE) && rst;
  assign bus.res_valid  = res_valid;
  assign bus.wb_en      = wb_en;
  assign bus.wb_data    = wb_data;
  assign bus.vf_en      = vf_en;
  assign bus.vf_data    = vf_data;
  assign bus.skip       = skip;
  assign bus.trap       = trap;
  assign bus.mem_valid  = mem_valid;
  assign bus.mem_offset = mem_offset;
  assign bus.mem_data   = mem_data;

  // Single-cycle result, computed straight from the accepted operands
  logic              sc_ok, sc_wb_en, sc_vf_en, sc_skip, sc_flag, key_hit;
  logic [DATA_W-1:0] sc_wb, immx;
  logic [DATA_W:0]   sum;

  always_comb begin
    immx    = DATA_W'(bus.imm);
    sum     = {1'b0, bus.vx} + {1'b0, bus.vy};
    key_hit = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (bus.vx == DATA_W'(k)) key_hit = bus.keys[k];
    sc_ok = 1'b1; sc_wb_en = 1'b0; sc_vf_en = 1'b0; sc_skip = 1'b0;
    sc_flag = 1'b0; sc_wb = '0;
    case (bus.op)
      OP_LD_B: begin sc_wb_en = 1'b1; sc_wb = immx; end
      OP_LD:   begin sc_wb_en = 1'b1; sc_wb = bus.vy; end
      OP_ADDI: begin sc_wb_en = 1'b1; sc_wb = bus.vx + immx; end
      OP_ADD:  begin sc_wb_en = 1'b1; sc_vf_en = 1'b1; sc_wb = sum[DATA_W-1:0]; sc_flag = sum[DATA_W]; end
      OP_SUB:  begin sc_wb_en = 1'b1; sc_vf_en = 1'b1; sc_wb = bus.vx - bus.vy; sc_flag = bus.vx >= bus.vy; end
      OP_SUBN: begin sc_wb_en = 1'b1; sc_vf_en = 1'b1; sc_wb = bus.vy - bus.vx; sc_flag = bus.vy >= bus.vx; end
      OP_OR:   begin sc_wb_en = 1'b1; sc_wb = bus.vx | bus.vy; end
      OP_AND:  begin sc_wb_en = 1'b1; sc_wb = bus.vx & bus.vy; end
      OP_XOR:  begin sc_wb_en = 1'b1; sc_wb = bus.vx ^ bus.vy; end
      OP_SHR:  begin sc_wb_en = 1'b1; sc_vf_en = 1'b1; sc_wb = bus.vx >> 1; sc_flag = bus.vx[0]; end
      OP_SHL:  begin sc_wb_en = 1'b1; sc_vf_en = 1'b1; sc_wb = bus.vx << 1; sc_flag = bus.vx[DATA_W-1]; end
      OP_RND:  begin sc_wb_en = 1'b1; sc_wb = bus.rnd & immx; end
      OP_SE_B:  sc_skip = bus.vx == immx;
      OP_SE:    sc_skip = bus.vx == bus.vy;
      OP_SNE_B: sc_skip = bus.vx != immx;
      OP_SNE:   sc_skip = bus.vx != bus.vy;
      OP_SKP:   sc_skip = key_hit;
      OP_SKNP:  sc_skip = !key_hit;
      default:  sc_ok = 1'b0;
    endcase
  end

  logic [KEY_W-1:0] low_idx;
  always_comb begin
    low_idx = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (bus.keys[k]) low_idx = KEY_W'(k);
  end

  // Double-dabble step: add 3 to any digit >= 5, then shift in the next bit
  logic [BCD_W-1:0] bcd_adj, bcd_nxt;
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++)
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    bcd_nxt = {bcd_adj[BCD_W-2:0], bin[DATA_W-1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      res_valid <= 1'b0; wb_en <= 1'b0; vf_en <= 1'b0; skip <= 1'b0; trap <= 1'b0;
      mem_valid <= 1'b0; wb_data <= '0; vf_data <= '0; mem_offset <= '0; mem_data <= '0;
      key_idx <= '0; bin <= '0; bcd <= '0; cnt <= '0;
    end else begin
      res_valid <= 1'b0; wb_en <= 1'b0; vf_en <= 1'b0; skip <= 1'b0; trap <= 1'b0;
      if (bus.flush) begin
        state     <= IDLE;
        mem_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (bus.in_valid) begin
            if (bus.op == OP_LD_K) begin
              state <= KEY_PRESS;
            end else if (bus.op == OP_BCD) begin
              state <= BCD_CONV;
              bin   <= bus.vx;
              bcd   <= '0;
              cnt   <= '0;
            end else if (sc_ok) begin
              res_valid <= 1'b1;
              wb_en     <= sc_wb_en;
              vf_en     <= sc_vf_en;
              skip      <= sc_skip;
              wb_data   <= sc_wb;
              vf_data   <= DATA_W'(sc_flag);
            end else begin
              trap <= 1'b1;
            end
          end
          KEY_PRESS: if (|bus.keys) begin
            key_idx <= low_idx;
            state   <= KEY_RELEASE;
          end
          KEY_RELEASE: if (!bus.keys[key_idx]) begin
            res_valid <= 1'b1;
            wb_en     <= 1'b1;
            wb_data   <= DATA_W'(key_idx);
            state     <= IDLE;
          end
          BCD_CONV: begin
            bcd <= bcd_nxt;
            bin <= bin << 1;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state      <= BCD_EMIT;
              mem_valid  <= 1'b1;
              mem_offset <= '0;
              mem_data   <= {4'd0, bcd_nxt[BCD_W-1 -: 4]};
            end
          end
          BCD_EMIT: if (bus.mem_ready) begin
            if (mem_offset == OFF_W'(DIGITS - 1)) begin
              mem_valid <= 1'b0;
              res_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              // bcd shifts so its top nibble is always the digit on the bus
              mem_offset <= mem_offset + 1'b1;
              mem_data   <= {4'd0, bcd[BCD_W-5 -: 4]};
              bcd        <= bcd << 4;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_chip8_exec_unit.sv
// Bench for chip8_exec_unit: vector table, randomized ops against an
// arithmetic reference model, and hand sequences for key wait, BCD and flush.
module tb_chip8_exec_unit;
  localparam int DATA_W = 8, NUM_KEYS = 16;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  chip8_exec_unit_if #(.DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS)) bus();
  chip8_exec_unit #(.DATA_W(DATA_W), .NUM_KEYS(NUM_KEYS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;

  typedef struct {
    int op, vx, vy, imm, keys;
    int rv, tr, wbe, wb, vfe, vf, sk;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model: plain integer arithmetic on 8-bit registers
  function automatic vec_t model(int op, int vx, int vy, int imm, int rnd, int keys);
    vec_t e = '{op, vx, vy, imm, keys, 1, 0, 0, 0, 0, 0, 0};
    case (op)
      10: begin e.wbe = 1; e.wb = imm; end
      11: begin e.wbe = 1; e.wb = vy; end
      21: begin e.wbe = 1; e.wb = (vx + imm) % 256; end
      22: begin e.wbe = 1; e.vfe = 1; e.wb = (vx + vy) % 256; e.vf = (vx + vy > 255) ? 1 : 0; end
      24: begin e.wbe = 1; e.vfe = 1; e.wb = (vx - vy + 256) % 256; e.vf = (vx >= vy) ? 1 : 0; end
      25: begin e.wbe = 1; e.vfe = 1; e.wb = (vy - vx + 256) % 256; e.vf = (vy >= vx) ? 1 : 0; end
      26: begin e.wbe = 1; e.wb = vx | vy; end
      27: begin e.wbe = 1; e.wb = vx & vy; end
      28: begin e.wbe = 1; e.wb = vx ^ vy; end
      29: begin e.wbe = 1; e.vfe = 1; e.wb = vx / 2; e.vf = vx % 2; end
      30: begin e.wbe = 1; e.vfe = 1; e.wb = (vx * 2) % 256; e.vf = vx / 128; end
      31: begin e.wbe = 1; e.wb = rnd & imm; end
      6:  e.sk = (vx == imm) ? 1 : 0;
      7:  e.sk = (vx == vy) ? 1 : 0;
      8:  e.sk = (vx != imm) ? 1 : 0;
      9:  e.sk = (vx != vy) ? 1 : 0;
      33: e.sk = (vx < NUM_KEYS) ? (keys >> vx) & 1 : 0;
      34: e.sk = (vx < NUM_KEYS) ? 1 - ((keys >> vx) & 1) : 1;
      default: begin e.rv = 0; e.tr = 1; end
    endcase
    return e;
  endfunction

  task automatic apply_vec(input vec_t v, input int rnd, input string tag);
    bus.op = v.op[5:0]; bus.vx = v.vx[7:0]; bus.vy = v.vy[7:0]; bus.imm = v.imm[7:0];
    bus.keys = v.keys[15:0]; bus.rnd = rnd[7:0]; bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    tick();
    chk({tag, "_res_valid"}, bus.res_valid, v.rv);
    chk({tag, "_trap"}, bus.trap, v.tr);
    if (v.rv != 0) begin
      chk({tag, "_wb_en"}, bus.wb_en, v.wbe);
      chk({tag, "_vf_en"}, bus.vf_en, v.vfe);
      chk({tag, "_skip"}, bus.skip, v.sk);
      if (v.wbe != 0) chk({tag, "_wb_data"}, bus.wb_data, v.wb);
      if (v.vfe != 0) chk({tag, "_vf_data"}, bus.vf_data, v.vf);
    end
  endtask

  task automatic run_bcd(input int v, input logic [7:0] pat, input bit rnd_rdy, input string tag);
    int d[3];
    int beat = 0, n = 0;
    bit bad = 0;
    d[0] = v / 100; d[1] = (v / 10) % 10; d[2] = v % 10;
    bus.op = 6'd18; bus.vx = v[7:0]; bus.in_valid = 1'b1; bus.mem_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (bus.mem_valid || bus.res_valid || bus.in_ready) bad = 1;
      tick();
    end
    chk({tag, "_conv_quiet"}, bad, 0);
    while (beat < 3 && n < 40) begin
      bus.mem_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : ((n < 8) ? pat[n] : 1'b1);
      chk({tag, "_mem_valid"}, bus.mem_valid, 1);
      chk({tag, "_offset"}, bus.mem_offset, beat);
      chk({tag, "_digit"}, bus.mem_data, d[beat]);
      chk({tag, "_in_ready_low"}, bus.in_ready, 0);
      chk({tag, "_no_early_res"}, bus.res_valid, 0);
      if (bus.mem_ready) beat++;
      n++;
      tick();
    end
    bus.mem_ready = 1'b0;
    chk({tag, "_beats"}, beat, 3);
    chk({tag, "_res_valid"}, bus.res_valid, 1);
    chk({tag, "_res_flags"}, {bus.wb_en, bus.vf_en, bus.skip, bus.mem_valid}, 0);
    tick();
    chk({tag, "_res_pulse"}, bus.res_valid, 0);
    chk({tag, "_ready_after"}, bus.in_ready, 1);
  endtask

  localparam int NV = 20;
  vec_t tbl[NV];

  initial begin
    tbl[0]  = '{22, 'hF0, 'h20, 0, 0,      1, 0, 1, 'h10, 1, 1, 0};
    tbl[1]  = '{24, 'h05, 'h07, 0, 0,      1, 0, 1, 'hFE, 1, 0, 0};
    tbl[2]  = '{6,  'h3C, 0, 'h3C, 0,      1, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{8,  'h3C, 0, 'h3C, 0,      1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{40, 1, 2, 3, 0,            0, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{32, 1, 2, 3, 0,            0, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{10, 0, 0, 'hA5, 0,         1, 0, 1, 'hA5, 0, 0, 0};
    tbl[7]  = '{30, 'h81, 0, 0, 0,         1, 0, 1, 'h02, 1, 1, 0};
    tbl[8]  = '{29, 'h81, 0, 0, 0,         1, 0, 1, 'h40, 1, 1, 0};
    tbl[9]  = '{25, 5, 7, 0, 0,            1, 0, 1, 'h02, 1, 1, 0};
    tbl[10] = '{33, 3, 0, 0, 'h0008,       1, 0, 0, 0, 0, 0, 1};
    tbl[11] = '{33, 20, 0, 0, 'hFFFF,      1, 0, 0, 0, 0, 0, 0};
    tbl[12] = '{34, 20, 0, 0, 'hFFFF,      1, 0, 0, 0, 0, 0, 1};
    tbl[13] = '{21, 'hFF, 0, 2, 0,         1, 0, 1, 'h01, 0, 0, 0};
    tbl[14] = '{7,  'h12, 'h12, 0, 0,      1, 0, 0, 0, 0, 0, 1};
    tbl[15] = '{24, 5, 5, 0, 0,            1, 0, 1, 'h00, 1, 1, 0};
    tbl[16] = '{11, 0, 'h77, 0, 0,         1, 0, 1, 'h77, 0, 0, 0};
    tbl[17] = '{28, 'hF0, 'h3C, 0, 0,      1, 0, 1, 'hCC, 0, 0, 0};
    tbl[18] = '{27, 'hF0, 'h3C, 0, 0,      1, 0, 1, 'h30, 0, 0, 0};
    tbl[19] = '{9,  1, 2, 0, 0,            1, 0, 0, 0, 0, 0, 1};

    bus.flush = 0; bus.in_valid = 0; bus.op = 0; bus.vx = 0; bus.vy = 0; bus.imm = 0;
    bus.keys = 0; bus.rnd = 0; bus.mem_ready = 0;

    // Reset
    #2 rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_pulses", {bus.res_valid, bus.wb_en, bus.vf_en, bus.skip, bus.mem_valid, bus.trap}, 0);
    chk("rst_data", {bus.wb_data, bus.vf_data, bus.mem_offset, bus.mem_data}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_ready", bus.in_ready, 1);

    // Vector table, applied back-to-back
    for (int i = 0; i < NV; i++) apply_vec(tbl[i], 0, $sformatf("vec%0d", i));
    bus.in_valid = 1'b0;

    // Randomized single-cycle and unsupported ops
    begin
      int pool[20] = '{6, 7, 8, 9, 10, 11, 21, 22, 24, 25, 26, 27, 28, 29, 30, 31, 33, 34, 0, 45};
      for (int i = 0; i < 200; i++) begin
        int op, vx, vy, imm, rnd, keys;
        op = (i % 8 == 7) ? $urandom_range(0, 63) : pool[$urandom_range(0, 19)];
        if (op == 14 || op == 18) op = 0;
        vx   = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 19) : $urandom_range(0, 255);
        vy   = ($urandom_range(0, 3) == 0) ? vx : $urandom_range(0, 255);
        imm  = ($urandom_range(0, 3) == 0) ? vx : $urandom_range(0, 255);
        rnd  = $urandom_range(0, 255);
        keys = $urandom_range(0, 65535);
        apply_vec(model(op, vx, vy, imm, rnd, keys), rnd, $sformatf("rnd%0d_op%0d", i, op));
      end
      bus.in_valid = 1'b0;
    end

    // BCD with stalls (ready 1,0,1,1), boundaries, then random stalls
    run_bcd('hFE, 8'b1111_1101, 1'b0, "bcd_fe");
    run_bcd(0, 8'hFF, 1'b0, "bcd_0");
    run_bcd(255, 8'hFF, 1'b0, "bcd_255");
    for (int i = 0; i < 6; i++) run_bcd($urandom_range(0, 255), 8'h00, 1'b1, $sformatf("bcd_r%0d", i));

    // Key wait: lowest pressed index latched, release of that key only
    bus.op = 6'd14; bus.keys = 0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("key_wait_ready", bus.in_ready, 0);
      chk("key_wait_res", bus.res_valid, 0);
      tick();
    end
    bus.keys = 16'h0028;
    tick();
    tick();
    chk("key_held_res", bus.res_valid, 0);
    bus.keys = 16'h0020;
    tick();
    bus.keys = 16'h0000;
    chk("key_res_valid", bus.res_valid, 1);
    chk("key_wb_en", bus.wb_en, 1);
    chk("key_wb_data", bus.wb_data, 3);
    chk("key_vf_skip", {bus.vf_en, bus.skip}, 0);
    tick();
    chk("key_res_pulse", bus.res_valid, 0);

    // Flush during BCD_CONV
    begin
      bit seen = 0;
      bus.op = 6'd18; bus.vx = 8'd200; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick(); tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_bcd_ready", bus.in_ready, 1);
      for (int i = 0; i < 14; i++) begin
        if (bus.mem_valid || bus.res_valid) seen = 1;
        tick();
      end
      chk("flush_bcd_quiet", seen, 0);
    end
    apply_vec('{22, 1, 2, 0, 0, 1, 0, 1, 3, 1, 0, 0}, 0, "post_flush_add");
    bus.in_valid = 1'b0;

    // Flush during KEY_PRESS with a same-cycle in_valid, then flush in IDLE
    bus.op = 6'd14; bus.keys = 0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.flush = 1'b1; bus.op = 6'd10; bus.imm = 8'h33; bus.in_valid = 1'b1;
    tick();
    chk("flush_key_ready", bus.in_ready, 1);
    chk("flush_key_res", bus.res_valid, 0);
    tick();
    chk("flush_idle_no_accept", bus.res_valid, 0);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    bus.keys = 16'h0001;
    tick(); tick();
    chk("flush_key_quiet", bus.res_valid, 0);
    bus.keys = 0;
    apply_vec('{22, 'h80, 'h80, 0, 0, 1, 0, 1, 0, 1, 1, 0}, 0, "post_flush_add2");
    bus.in_valid = 1'b0;

    // Async reset mid-KEY_RELEASE
    apply_vec('{10, 0, 0, 'hA5, 0, 1, 0, 1, 'hA5, 0, 0, 0}, 0, "pre_rst_ld");
    bus.op = 6'd14; bus.keys = 16'h0001; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("rel_wait", bus.res_valid, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", bus.in_ready, 0);
    chk("arst_pulses", {bus.res_valid, bus.wb_en, bus.vf_en, bus.skip, bus.mem_valid, bus.trap}, 0);
    chk("arst_wb_data", bus.wb_data, 0);
    chk("arst_mem", {bus.mem_offset, bus.mem_data}, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("arst_idle", bus.in_ready, 1);
    bus.keys = 0;
    tick();
    chk("arst_no_res", bus.res_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
